// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the memory stage: load/store kinds, bus size codes and
// the bus-transaction FSM states.
package mem_lsu_pkg;

  localparam logic [3:0] LS_LB  = 4'd0;
  localparam logic [3:0] LS_LBU = 4'd1;
  localparam logic [3:0] LS_LH  = 4'd2;
  localparam logic [3:0] LS_LHU = 4'd3;
  localparam logic [3:0] LS_LW  = 4'd4;
  localparam logic [3:0] LS_SB  = 4'd5;
  localparam logic [3:0] LS_SH  = 4'd6;
  localparam logic [3:0] LS_SW  = 4'd7;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } lsu_state_e;

  function automatic logic ls_is_store(input logic [3:0] sel);
    return (sel == LS_SB) || (sel == LS_SH) || (sel == LS_SW);
  endfunction

  function automatic logic [1:0] ls_size(input logic [3:0] sel);
    logic [1:0] sz;
    case (sel)
      LS_LB, LS_LBU, LS_SB: sz = SZ_BYTE;
      LS_LH, LS_LHU, LS_SH: sz = SZ_HALF;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_lsu_ls_align.sv
// Byte-lane alignment for the memory stage: store strobes/data replication,
// load byte/half extraction with sign or zero extension, misalignment detect.
module ls_align
  import mem_lsu_pkg::*;
(
  input  logic [3:0]  ls_sel,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rt_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [1:0]  size;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    size    = ls_size(ls_sel);

    misalign = ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));

    wstrb = '0;
    wdata = rt_data;
    case (ls_sel)
      LS_SB: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{rt_data[7:0]}};
      end
      LS_SH: begin
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{rt_data[15:0]}};
      end
      LS_SW:   wstrb = 4'b1111;
      default: wstrb = '0;
    endcase

    case (ls_sel)
      LS_LB:   load_data = {{24{byte_v[7]}}, byte_v};
      LS_LBU:  load_data = {24'd0, byte_v};
      LS_LH:   load_data = {{16{half_v[15]}}, half_v};
      LS_LHU:  load_data = {16'd0, half_v};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage: EX/MEM pipeline register plus the load/store bus transaction
// FSM, producing write-back data, hilo forwarding copies and a stall request.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_res,
  input  logic [31:0] ex_rt_data,
  input  logic        ex_w_reg_ena,
  input  logic [4:0]  ex_w_reg_dst,
  input  logic        ex_ls_ena,
  input  logic [3:0]  ex_ls_sel,
  input  logic [1:0]  ex_w_hilo_ena,
  input  logic [31:0] ex_hi_res,
  input  logic [31:0] ex_lo_res,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_ok,
  input  logic [31:0] data_rdata,
  output logic        mem_stall_req,
  output logic [1:0]  mem_addr_err,
  output logic        mem_w_reg_ena,
  output logic [4:0]  mem_w_reg_dst,
  output logic [31:0] mem_w_reg_data,
  output logic [1:0]  memc_w_hilo_ena,
  output logic [31:0] memc_hi_res,
  output logic [31:0] memc_lo_res
);

  lsu_state_e  state;
  logic        valid, done, kill;
  logic [31:0] rdata_q;
  logic [31:0] alu_res, rt_data, hi_res, lo_res;
  logic        w_reg_ena, ls_ena;
  logic [4:0]  w_reg_dst;
  logic [3:0]  ls_sel;
  logic [1:0]  w_hilo_ena;

  logic        is_store, is_load, misalign, err, pending;
  logic [3:0]  wstrb;
  logic [31:0] wdata, load_data;

  ls_align u_ls_align (
    .ls_sel    (ls_sel),
    .addr_lo   (alu_res[1:0]),
    .rt_data   (rt_data),
    .rdata     (rdata_q),
    .wstrb     (wstrb),
    .wdata     (wdata),
    .load_data (load_data),
    .misalign  (misalign)
  );

  always_comb begin
    is_store = ls_ena & ls_is_store(ls_sel);
    is_load  = ls_ena & ~ls_is_store(ls_sel);
    err      = valid & ls_ena & misalign;
    pending  = valid & ls_ena & ~err & ~done;

    mem_addr_err  = {err & is_store, err & ~is_store};
    data_req      = ((state == ST_IDLE) & pending) | (state == ST_REQ);
    mem_stall_req = pending | (state == ST_DRAIN);

    data_wr    = is_store;
    data_size  = ls_size(ls_sel);
    data_addr  = alu_res;
    data_wstrb = wstrb;
    data_wdata = wdata;

    mem_w_reg_ena  = valid & w_reg_ena & ~err & (~is_load | done) & ~kill;
    mem_w_reg_dst  = w_reg_dst;
    mem_w_reg_data = is_load ? load_data : alu_res;

    memc_w_hilo_ena = valid ? w_hilo_ena : '0;
    memc_hi_res     = valid ? hi_res : '0;
    memc_lo_res     = valid ? lo_res : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_res    <= '0;
      rt_data    <= '0;
      w_reg_ena  <= 1'b0;
      w_reg_dst  <= '0;
      ls_ena     <= 1'b0;
      ls_sel     <= '0;
      w_hilo_ena <= '0;
      hi_res     <= '0;
      lo_res     <= '0;
    end else if (!mem_stall_req) begin
      alu_res    <= ex_alu_res;
      rt_data    <= ex_rt_data;
      w_reg_ena  <= ex_w_reg_ena;
      w_reg_dst  <= ex_w_reg_dst;
      ls_ena     <= ex_ls_ena;
      ls_sel     <= ex_ls_sel;
      w_hilo_ena <= ex_w_hilo_ena;
      hi_res     <= ex_hi_res;
      lo_res     <= ex_lo_res;
    end
  end

  // A flushed request that is not yet accepted keeps valid (and so the stall
  // and the request fields) until addr_ok; kill marks it for discard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      valid   <= 1'b0;
      done    <= 1'b0;
      kill    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (!mem_stall_req) begin
        valid <= ex_valid & ~flush;
        done  <= 1'b0;
        kill  <= 1'b0;
      end
      unique case (state)
        ST_IDLE: begin
          if (pending) begin
            if (flush) begin
              if (data_addr_ok && data_ok) begin
                valid <= 1'b0;
              end else if (data_addr_ok) begin
                valid <= 1'b0;
                state <= ST_DRAIN;
              end else begin
                kill  <= 1'b1;
                state <= ST_REQ;
              end
            end else if (data_addr_ok && data_ok) begin
              done    <= 1'b1;
              rdata_q <= data_rdata;
            end else if (data_addr_ok) begin
              state <= ST_WAIT;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (data_addr_ok) begin
            if (kill || flush) begin
              valid <= 1'b0;
              kill  <= 1'b0;
              state <= data_ok ? ST_IDLE : ST_DRAIN;
            end else if (data_ok) begin
              done    <= 1'b1;
              rdata_q <= data_rdata;
              state   <= ST_IDLE;
            end else begin
              state <= ST_WAIT;
            end
          end else if (flush) begin
            kill <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (flush) begin
            valid <= 1'b0;
            state <= data_ok ? ST_IDLE : ST_DRAIN;
          end else if (data_ok) begin
            done    <= 1'b1;
            rdata_q <= data_rdata;
            state   <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (data_ok) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
